dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target serving the CPU core's stage-3 data port: accepts loads and stores sized by a RISC-V funct3 code, and returns load data in the same cycle.
- Stores are posted into a one-entry store buffer. The buffer commits to the word array on the next clock edge and forwards its bytes to any immediately following load.
- Detects misaligned, illegal-size and conflicting accesses, and records them in sticky error/status registers.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- CNT_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MEM_addr  in  32  byte address from CPU.
- MEM_WR_out  in  32  store data from CPU; bytes are right-justified.
- MEM_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MEM_rd_en  in  1  load request this cycle.
- MEM_wr_en  in  1  store request this cycle.
- MEM_data  out  32  load data (combinational), already sign/zero extended.
- err_clr  in  1  synchronous clear of the error state.
- mem_err  out  1  sticky error flag.
- err_count  out  CNT_W  saturating count of faulting accesses.
- err_addr  out  32  MEM_addr of the most recent faulting access.

Behaviour:
- Reset (async, Reset=0):
  - Store buffer invalidated; a pending uncommitted store is discarded.
  - mem_err=0, err_count=0, err_addr=0.
  - Array contents are not reset.
  - MEM_data=0 while no load is requested.
- Word index = MEM_addr[log2(DEPTH)+1:2]; byte offset = MEM_addr[1:0].
- Fault in cycle N is any of:
  - MEM_type in {011, 110, 111} (illegal size).
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=00.
  - MEM_rd_en and MEM_wr_en both high.
- Faulting store: no buffer capture. Faulting load: MEM_data=0.
- Store (MEM_wr_en, no fault):
  - Byte mask per size/offset: B one lane, H lanes {1:0} or {3:2}, W all four lanes.
  - Data is shifted into its lane.
  - At edge N the address, mask and data are captured into the buffer and valid is set.
- Commit:
  - A valid buffer writes its masked bytes to the array at the next edge (edge N+1), unconditionally.
  - If a new store arrives in cycle N+1, the old entry commits and the new entry is captured at the same edge.
  - A buffer that commits with no new store becomes invalid.
- Load (MEM_rd_en, no fault), zero latency:
  - Array word is read combinationally.
  - If the buffer is valid and the word index matches, masked buffer bytes override array bytes.
  - Lane is selected by offset, then extended: B/H sign-extended, BU/HU zero-extended, W as-is.
- MEM_data is 0 when MEM_rd_en=0.
- Idle cycles (neither enable) only drain the buffer.
- Error registers, updated at the edge ending the faulting cycle:
  - mem_err is set to 1.
  - err_count increments and saturates at 2^CNT_W-1.
  - err_addr is loaded with MEM_addr.
- err_clr=1 with no fault: all three registers clear.
- err_clr and a fault in the same cycle: the fault wins, giving mem_err=1, err_count=1, err_addr=new address.
- Without DMEM_BOUNDS_EN, addresses above the array size alias modulo DEPTH*4.

Optional Feature:
- Macro: DMEM_BOUNDS_EN.
- Defined: an access with MEM_addr >= DEPTH*4 is an additional fault class.
  - A store is dropped; a load returns 0; the error registers update.
- Undefined: upper address bits are ignored and the address wraps.

Decomposition:
- Package dmem_pkg holds:
  - MT_B/MT_H/MT_W/MT_BU/MT_HU localparams.
  - The lane-mask function.
  - A struct type for the store buffer entry (idx, mask, data, valid).
- One sub-module, dmem_lane_align, is purely combinational:
  - Computes the fault/misalign flag and byte mask.
  - Shifts store data into lanes.
  - Selects and extends load data.
- Top level owns the array, the buffer and the error registers.

Test Plan:
- SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> 0xDEADBEEF via forward; LW two cycles later -> 0xDEADBEEF from array.
- After the word above, SB 0x80 @0x11, next cycle LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0xDEAD80EF.
- LH @0x13 -> MEM_data=0, mem_err=1, err_count=1, err_addr=0x13; SW @0x22 -> array unchanged, err_count=2.
- Assert err_clr alongside a fault at MEM_type=011, addr 0x40 -> err_count=1, err_addr=0x40; err_clr alone next cycle -> all error registers 0.
- SW 0x11111111 @0x20 then Reset low before the next edge -> the pending store is lost; LW @0x20 after reset returns the prior array value.
- With DMEM_BOUNDS_EN and DEPTH=1024: SW @0x1000 -> fault, LW @0x0 is unaffected. Without it: SW @0x1000 aliases to 0x0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: funct3 size codes,
// byte-lane mask derivation and the store-buffer entry layout.
package dmem_pkg;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    // idx keeps the full word address; the top compares only the bits it indexes with.
    typedef struct packed {
        logic [29:0] idx;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        valid;
    } sb_entry_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] mt, input logic [1:0] off);
        case (mt)
            MT_B, MT_BU: return 4'b0001 << off;
            MT_H, MT_HU: return off[1] ? 4'b1100 : 4'b0011;
            MT_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: size/alignment fault, byte mask, store lane shift
// and load lane select with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic        size_fault,
    output logic [3:0]  mask,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic        is_half;
    logic        is_word;
    logic        bad_code;
    logic [31:0] ld_shift;

    always_comb begin
        bad_code   = (mem_type == 3'b011) || (mem_type == 3'b110) || (mem_type == 3'b111);
        is_half    = (mem_type == MT_H) || (mem_type == MT_HU);
        is_word    = (mem_type == MT_W);
        size_fault = bad_code || (is_half && offset[0]) || (is_word && (offset != 2'b00));
        mask       = lane_mask(mem_type, offset);
        st_lanes   = st_data << {offset, 3'b000};
        ld_shift   = ld_word >> {offset, 3'b000};
        case (mem_type)
            MT_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            MT_BU:   ld_data = {24'h0, ld_shift[7:0]};
            MT_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            MT_HU:   ld_data = {16'h0, ld_shift[15:0]};
            MT_W:    ld_data = ld_shift;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target with a one-entry posted store buffer, same-cycle loads
// with store forwarding, and sticky error registers. Optional: DMEM_BOUNDS_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      MEM_addr,
    input  logic [31:0]      MEM_WR_out,
    input  logic [2:0]       MEM_type,
    input  logic             MEM_rd_en,
    input  logic             MEM_wr_en,
    output logic [31:0]      MEM_data,
    input  logic             err_clr,
    output logic             mem_err,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      err_addr
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [31:0]   mem [DEPTH];
    sb_entry_t     sb_p1;
    logic [AW-1:0] idx_p0;
    logic          size_fault_p0;
    logic          oob_p0;
    logic          fault_p0;
    logic          store_ok_p0;
    logic          load_ok_p0;
    logic [3:0]    mask_p0;
    logic [31:0]   st_lanes_p0;
    logic [31:0]   rd_word_p0;
    logic [31:0]   ld_data_p0;
    logic          addr_unused;

    assign idx_p0      = MEM_addr[AW+1:2];
    assign addr_unused = ^{MEM_addr[31:AW+2], sb_p1.idx[29:AW]};

`ifdef DMEM_BOUNDS_EN
    assign oob_p0 = (MEM_addr >= 32'(DEPTH * 4));
`else
    assign oob_p0 = 1'b0;
`endif

    dmem_lane_align u_align (
        .mem_type   (MEM_type),
        .offset     (MEM_addr[1:0]),
        .st_data    (MEM_WR_out),
        .ld_word    (rd_word_p0),
        .size_fault (size_fault_p0),
        .mask       (mask_p0),
        .st_lanes   (st_lanes_p0),
        .ld_data    (ld_data_p0)
    );

    assign fault_p0    = (MEM_rd_en || MEM_wr_en) &&
                         (size_fault_p0 || oob_p0 || (MEM_rd_en && MEM_wr_en));
    assign store_ok_p0 = MEM_wr_en && !fault_p0;
    assign load_ok_p0  = MEM_rd_en && !fault_p0;

    // Array word with any pending buffered bytes for the same word laid over it.
    always_comb begin
        rd_word_p0 = mem[idx_p0];
        if (sb_p1.valid && (sb_p1.idx[AW-1:0] == idx_p0)) begin
            for (int b = 0; b < 4; b++) begin
                if (sb_p1.mask[b]) rd_word_p0[8*b +: 8] = sb_p1.data[8*b +: 8];
            end
        end
    end

    assign MEM_data = load_ok_p0 ? ld_data_p0 : 32'h0;

    // ---- p0 -> p1: store buffer capture (only valid is reset) ----
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sb_p1.valid <= 1'b0;
        end else begin
            sb_p1.valid <= store_ok_p0;
            if (store_ok_p0) begin
                sb_p1.idx  <= MEM_addr[31:2];
                sb_p1.mask <= mask_p0;
                sb_p1.data <= st_lanes_p0;
            end
        end
    end

    // ---- p1 -> array: commit ----
    always_ff @(posedge CLK) begin
        if (sb_p1.valid) begin
            for (int b = 0; b < 4; b++) begin
                if (sb_p1.mask[b]) mem[sb_p1.idx[AW-1:0]][8*b +: 8] <= sb_p1.data[8*b +: 8];
            end
        end
    end

    // A fault in the same cycle as err_clr restarts the count at one.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mem_err   <= 1'b0;
            err_count <= '0;
            err_addr  <= 32'h0;
        end else if (fault_p0) begin
            mem_err   <= 1'b1;
            err_count <= err_clr ? CNT_W'(1) : sat_inc(err_count);
            err_addr  <= MEM_addr;
        end else if (err_clr) begin
            mem_err   <= 1'b0;
            err_count <= '0;
            err_addr  <= 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: forwarding, lane extension, faults,
// error-register clear/saturation, reset discard and address aliasing/bounds.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             Reset = 1'b0;
    logic [31:0]      MEM_addr = '0;
    logic [31:0]      MEM_WR_out = '0;
    logic [2:0]       MEM_type = '0;
    logic             MEM_rd_en = 1'b0;
    logic             MEM_wr_en = 1'b0;
    logic [31:0]      MEM_data;
    logic             err_clr = 1'b0;
    logic             mem_err;
    logic [CNT_W-1:0] err_count;
    logic [31:0]      err_addr;

    int n_checks = 0;
    int n_fails  = 0;

    dmem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .MEM_addr   (MEM_addr),
        .MEM_WR_out (MEM_WR_out),
        .MEM_type   (MEM_type),
        .MEM_rd_en  (MEM_rd_en),
        .MEM_wr_en  (MEM_wr_en),
        .MEM_data   (MEM_data),
        .err_clr    (err_clr),
        .mem_err    (mem_err),
        .err_count  (err_count),
        .err_addr   (err_addr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 2 units later.
    task automatic drive(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d, input logic clr);
        @(negedge CLK);
        MEM_rd_en = rd; MEM_wr_en = wr; MEM_type = t;
        MEM_addr = a; MEM_WR_out = d; err_clr = clr;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_err(input string tag, input logic e, input logic [CNT_W-1:0] c,
                             input logic [31:0] a);
        check({tag, "_mem_err"}, 32'(mem_err), 32'(e));
        check({tag, "_count"}, 32'(err_count), 32'(c));
        check({tag, "_addr"}, err_addr, a);
    endtask

    initial begin
        #1;
        check_err("reset", 1'b0, 8'd0, 32'h0);
        check("reset_data", MEM_data, 32'h0);
        repeat (2) @(negedge CLK);
        Reset = 1'b1;

        drive(0, 1, 3'b010, 32'h20, 32'h22222222, 0);
        idle();

        drive(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_fwd", MEM_data, 32'hDEADBEEF);
        idle();
        check("idle_data", MEM_data, 32'h0);
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_array", MEM_data, 32'hDEADBEEF);

        drive(0, 1, 3'b000, 32'h11, 32'h00000080, 0);
        drive(1, 0, 3'b000, 32'h11, 32'h0, 0);
        check("lb_fwd", MEM_data, 32'hFFFFFF80);
        drive(1, 0, 3'b100, 32'h11, 32'h0, 0);
        check("lbu", MEM_data, 32'h00000080);
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_after_sb", MEM_data, 32'hDEAD80EF);
        drive(1, 0, 3'b001, 32'h12, 32'h0, 0);
        check("lh", MEM_data, 32'hFFFFDEAD);
        drive(1, 0, 3'b101, 32'h12, 32'h0, 0);
        check("lhu", MEM_data, 32'h0000DEAD);

        drive(0, 1, 3'b000, 32'h12, 32'hFFFFFF7F, 0);
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_merge_fwd", MEM_data, 32'hDE7F80EF);
        check("no_err_yet", 32'(mem_err), 32'h0);

        drive(1, 0, 3'b001, 32'h13, 32'h0, 0);
        check("lh_mis_data", MEM_data, 32'h0);
        idle();
        check_err("lh_mis", 1'b1, 8'd1, 32'h13);
        drive(0, 1, 3'b010, 32'h22, 32'h12345678, 0);
        idle();
        check_err("sw_mis", 1'b1, 8'd2, 32'h22);
        drive(1, 0, 3'b010, 32'h20, 32'h0, 0);
        check("sw_mis_dropped", MEM_data, 32'h22222222);

        drive(1, 1, 3'b010, 32'h10, 32'h55555555, 0);
        check("rdwr_data", MEM_data, 32'h0);
        idle();
        check("rdwr_count", 32'(err_count), 32'd3);
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        check("rdwr_no_store", MEM_data, 32'hDE7F80EF);

        drive(1, 0, 3'b011, 32'h40, 32'h0, 1);
        check("clr_fault_data", MEM_data, 32'h0);
        drive(0, 0, 3'b000, 32'h0, 32'h0, 1);
        check_err("clr_fault", 1'b1, 8'd1, 32'h40);
        idle();
        check_err("clr_only", 1'b0, 8'd0, 32'h0);

        for (int i = 0; i < 260; i++) drive(1, 0, 3'b110, 32'h100 + 32'(i), 32'h0, 0);
        idle();
        check_err("saturate", 1'b1, 8'd255, 32'h203);
        drive(0, 0, 3'b000, 32'h0, 32'h0, 1);

        drive(1, 0, 3'b001, 32'h13, 32'h0, 0);
        drive(0, 1, 3'b010, 32'h20, 32'h11111111, 0);
        check("pre_reset_err", 32'(mem_err), 32'h1);
        Reset = 1'b0;
        #1;
        check_err("async_reset", 1'b0, 8'd0, 32'h0);
        @(negedge CLK);
        MEM_rd_en = 0; MEM_wr_en = 0;
        #2 Reset = 1'b1;
        drive(1, 0, 3'b010, 32'h20, 32'h0, 0);
        check("reset_discard", MEM_data, 32'h22222222);

        drive(0, 1, 3'b010, 32'h0, 32'h0A0B0C0D, 0);
        idle();
        drive(0, 1, 3'b010, 32'h1000, 32'hCAFEF00D, 0);
        idle();
`ifdef DMEM_BOUNDS_EN
        check_err("oob_store", 1'b1, 8'd1, 32'h1000);
        drive(1, 0, 3'b010, 32'h0, 32'h0, 0);
        check("oob_lw0", MEM_data, 32'h0A0B0C0D);
        drive(1, 0, 3'b010, 32'h1000, 32'h0, 0);
        check("oob_load", MEM_data, 32'h0);
`else
        check("alias_no_err", 32'(mem_err), 32'h0);
        drive(1, 0, 3'b010, 32'h0, 32'h0, 0);
        check("alias_lw0", MEM_data, 32'hCAFEF00D);
        drive(1, 0, 3'b010, 32'h1000, 32'h0, 0);
        check("alias_lw1000", MEM_data, 32'hCAFEF00D);
`endif
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
